multdiv_iter: RTL and testbench

//  Iterative signed 32-bit multiply/divide unit in the execute stage, beside the combinational ALU.
//  It consumes the same operand buses the ALU receives.
//  Its result, exception flag and ready strobe feed the same execute-to-memory result mux as the ALU's

---
 rtl/multdiv_iter_if.sv | 24 ++
 rtl/multdiv_iter.sv | 151 +++++++++++++++
 tb/tb_multdiv_iter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/multdiv_iter_if.sv
// Operand, control and result bus between the execute stage and the iterative multiply/divide unit.
// The pipeline side holds the master modport; the unit holds the slave modport.
interface multdiv_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 shift-add) / divide (non-restoring) unit, one iteration per clock.
// Both operations run on operand magnitudes and apply the result sign in the final BUSY cycle.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic               is_div;
    logic               negate;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   operand;    // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;

    logic             start;
    logic             is_last;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Exactly one start strobe; both high together is treated as no request.
    assign start   = bus.ctrl_MULT ^ bus.ctrl_DIV;
    assign is_last = (count == LAST);

    // |-2^(WIDTH-1)| wraps to itself, which read as unsigned is the correct magnitude.
    assign mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // ---------------------------------------------------------------- iteration step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, operand} : '0);
    assign prod_step = {mul_sum, prod[WIDTH-1:1]};

    // The partial remainder stays within [-2d, 2d), so dropping its top bit on the shift is safe.
    assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign rem_step  = rem[WIDTH] ? rem_shift + {1'b0, operand}
                                  : rem_shift - {1'b0, operand};
    assign quo_step  = {quo[WIDTH-2:0], ~rem_step[WIDTH]};

    // ---------------------------------------------------------------- result formation
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic               mul_exc;
    logic [WIDTH-1:0]   final_result;
    logic               final_exc;

    assign prod_signed = negate ? -prod : prod;
    assign quo_signed  = negate ? -quo : quo;
    assign mul_exc     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        final_result = prod_signed[WIDTH-1:0];
        final_exc    = mul_exc;
        if (is_div) begin
            final_result = div_zero ? '0 : quo_signed;
            final_exc    = div_zero | div_ovf;
        end
    end

    // ---------------------------------------------------------------- control FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (start) state_next = BUSY;
                     else if (is_last) state_next = DONE;
            DONE:    state_next = start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    // A start in any state reloads the operands, which is also how an in-flight operation is aborted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the datapath is reset too, so an aborted operation leaves nothing observable behind.
            count    <= '0;
            is_div   <= 1'b0;
            negate   <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            operand  <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (start) begin
            count    <= '0;
            is_div   <= bus.ctrl_DIV;
            negate   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div_zero <= ~|bus.data_operandB;
            div_ovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.data_operandB);
            operand  <= bus.ctrl_DIV ? mag_b : mag_a;
            prod     <= {{WIDTH{1'b0}}, mag_b};
            rem      <= '0;
            quo      <= mag_a;
        end else if (state == BUSY) begin
            if (!is_last) begin
                count <= count + 1'b1;
                if (is_div) begin
                    rem <= rem_step;
                    quo <= quo_step;
                end else begin
                    prod <= prod_step;
                end
            end else begin
                result_q <= final_result;
                exc_q    <= final_exc;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = (state == BUSY);

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed self-checking bench for multdiv_iter: latency, multiply/divide results and exceptions,
// abort/restart, ignored double start, and asynchronous reset mid-operation.
module tb_multdiv_iter;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   edges;
    int   early_rdy;

    multdiv_iter_if bus_if ();

    multdiv_iter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulses one start strobe for a single edge, then scrambles the operand buses.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic div, input string tag);
        @(negedge clock);
        bus_if.data_operandA = a;
        bus_if.data_operandB = b;
        bus_if.ctrl_MULT     = !div;
        bus_if.ctrl_DIV      = div;
        @(posedge clock);
        #1;
        bus_if.ctrl_MULT     = 1'b0;
        bus_if.ctrl_DIV      = 1'b0;
        bus_if.data_operandA = 32'hDEAD_BEEF;
        bus_if.data_operandB = 32'h1357_9BDF;
        check({tag, " busy_after_start"}, {31'b0, bus_if.busy}, 32'd1);
    endtask

    // Counts edges until RDY is seen; 0 means it never came within the budget.
    task automatic wait_rdy(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (bus_if.data_resultRDY) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic div,
                          input logic [31:0] exp_res, input logic exp_exc, input string tag);
        int n;
        start_op(a, b, div, tag);
        wait_rdy(n);
        check({tag, " latency"}, n, 32'd33);
        check({tag, " result"}, bus_if.data_result, exp_res);
        check({tag, " exception"}, {31'b0, bus_if.data_exception}, {31'b0, exp_exc});
        check({tag, " busy_on_rdy"}, {31'b0, bus_if.busy}, 32'd0);
        @(posedge clock);
        #1;
        check({tag, " rdy_one_cycle"}, {31'b0, bus_if.data_resultRDY}, 32'd0);
        check({tag, " result_held"}, bus_if.data_result, exp_res);
    endtask

    initial begin
        reset                = 1'b0;
        bus_if.data_operandA = '0;
        bus_if.data_operandB = '0;
        bus_if.ctrl_MULT     = 1'b0;
        bus_if.ctrl_DIV      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset result", bus_if.data_result, 32'd0);
        check("reset exception", {31'b0, bus_if.data_exception}, 32'd0);
        check("reset rdy", {31'b0, bus_if.data_resultRDY}, 32'd0);
        check("reset busy", {31'b0, bus_if.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op(32'd7,          32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 1'b0, "mul 7*-3");
        run_op(32'h0001_0000,  32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1, "mul 2^16*2^16");
        run_op(32'h8000_0000,  32'd1,         1'b0, 32'h8000_0000, 1'b0, "mul min*1");
        run_op(32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD, 1'b0, "div -7/2");
        run_op(32'd100,        32'd0,         1'b1, 32'h0000_0000, 1'b1, "div 100/0");

        // Abort a multiply part-way with a divide, then inject an ignored double start.
        start_op(32'd6, 32'd7, 1'b0, "abort mul");
        repeat (10) @(posedge clock);
        start_op(32'd20, 32'd4, 1'b1, "abort div");
        early_rdy = 0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (bus_if.data_resultRDY) early_rdy++;
        end
        @(negedge clock);
        bus_if.data_operandA = 32'd100;
        bus_if.data_operandB = 32'd1;
        bus_if.ctrl_MULT     = 1'b1;
        bus_if.ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        bus_if.ctrl_MULT = 1'b0;
        bus_if.ctrl_DIV  = 1'b0;
        if (bus_if.data_resultRDY) early_rdy++;
        check("abort no_early_rdy", early_rdy, 32'd0);
        check("double_start busy", {31'b0, bus_if.busy}, 32'd1);
        wait_rdy(edges);
        check("abort latency_after_double", edges, 32'd27);
        check("abort result", bus_if.data_result, 32'd5);
        check("abort exception", {31'b0, bus_if.data_exception}, 32'd0);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, "div min/-1");

        // Asynchronous reset between edges while a multiply is in flight.
        start_op(32'h1234_5678, 32'd2, 1'b0, "reset mul");
        repeat (8) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset result", bus_if.data_result, 32'd0);
        check("async_reset exception", {31'b0, bus_if.data_exception}, 32'd0);
        check("async_reset rdy", {31'b0, bus_if.data_resultRDY}, 32'd0);
        check("async_reset busy", {31'b0, bus_if.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        early_rdy = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus_if.data_resultRDY) early_rdy++;
        end
        check("post_reset no_rdy", early_rdy, 32'd0);
        check("post_reset busy", {31'b0, bus_if.busy}, 32'd0);

        run_op(32'd3, 32'd3, 1'b0, 32'd9, 1'b0, "mul 3*3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
